// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//
// Iterative multiply/divide unit for the MIPS-32 EX stage. It executes MULT,
// MULTU, DIV and DIVU into the HI/LO register pair, which the unit owns. One
// operation runs at a time: one shift-add (multiply) or restoring (divide)
// step per cycle, then a single sign-fix/commit cycle. The pipeline is
// stalled while an operation is in flight. An MFHI/MFLO that arrives during
// an operation is also stalled, so it reads the committed result.
//
// Optional build macro:
//   MDU_EARLY_EXIT_EN - multiply stops iterating as soon as the remaining
//                       multiplier bits are all zero. Results are identical.
//                       Divide latency does not change.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        EX-stage R-type instruction valid
//   Funct        instruction funct field
//   Op_A         rs operand (multiplicand / dividend)
//   Op_B         rt operand (multiplier / divisor)
//   flush        pipeline flush; aborts the in-flight operation
//   busy         operation in progress (MUL, DIV, FIX)
//   done         one-cycle pulse: HI/LO just committed
//   stall        hold IF/ID/EX
//   div_by_zero  sticky until the next accepted operation
//   HI, LO       architectural HI/LO registers
// -----------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Architectural / control state
  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  // Datapath state
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // product accumulator
  logic [WIDTH-1:0]   rem_q, rem_d;    // divide remainder
  logic [WIDTH-1:0]   sreg_q, sreg_d;  // multiplier, or dividend shifting into quotient
  logic [WIDTH-1:0]   areg_q, areg_d;  // multiplicand, or divisor
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // product / quotient is negative
  logic               neg_rem_q, neg_rem_d;  // dividend was negative

  // ---------------------------------------------------------------------------
  // Funct decode and operand magnitudes
  // ---------------------------------------------------------------------------
  logic             is_muldiv, is_mf, op_signed, op_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // MULT/MULTU/DIV/DIVU share the prefix 0110; bit 1 selects divide and
  // bit 0 selects unsigned.
  assign is_muldiv = (Funct[5:2] == 4'b0110);
  assign is_mf     = (Funct == F_MFHI) || (Funct == F_MFLO);
  assign op_div    = Funct[1];
  assign op_signed = ~Funct[0];

  assign a_neg = op_signed & Op_A[WIDTH-1];
  assign b_neg = op_signed & Op_B[WIDTH-1];
  // The magnitude of the most negative value wraps to itself. Read as
  // unsigned, that is the correct magnitude 2^(WIDTH-1).
  assign a_mag = a_neg ? -Op_A : Op_A;
  assign b_mag = b_neg ? -Op_B : Op_B;

  // ---------------------------------------------------------------------------
  // Multiply step: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right one place.
  // After k steps the accumulator holds the partial product scaled by
  // 2^(WIDTH-k).
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 last_step;
  logic                 mul_exit;
  logic [2*WIDTH-1:0]   mul_final;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (sreg_q[0] ? areg_q : {WIDTH{1'b0}})};
  assign acc_step  = {mul_sum, acc_q[WIDTH-1:1]};
  assign last_step = (cnt_q == LAST_CNT);

`ifdef MDU_EARLY_EXIT_EN
  // Once no multiplier bits remain, the partial product is complete. Undo
  // the outstanding 2^(WIDTH-1-cnt) scaling in one shift.
  logic [CNT_W-1:0] mul_shift;
  assign mul_shift = LAST_CNT - cnt_q;
  assign mul_exit  = last_step || (sreg_q[WIDTH-1:1] == '0);
  assign mul_final = acc_step >> mul_shift;
`else
  assign mul_exit  = last_step;
  assign mul_final = acc_step;
`endif

  // ---------------------------------------------------------------------------
  // Restoring divide step. The trial partial remainder is WIDTH+1 bits. When
  // it is at least the divisor, the difference is below 2^WIDTH, so a
  // WIDTH-bit subtraction is exact.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   div_trial;
  logic             div_ge;

  assign div_trial = {rem_q, sreg_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, areg_q});

  // ---------------------------------------------------------------------------
  // Sign correction applied in FIX
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_res_q ? -acc_q  : acc_q;
  assign quo_fix  = neg_res_q ? -sreg_q : sreg_q;
  assign rem_fix  = neg_rem_q ? -rem_q  : rem_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    sreg_d    = sreg_q;
    areg_d    = areg_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      // DONE behaves like IDLE for acceptance, which gives back-to-back ops.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && is_muldiv) begin
          dbz_d     = 1'b0;
          cnt_d     = '0;
          acc_d     = '0;
          rem_d     = '0;
          is_div_d  = op_div;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (op_div) begin
            areg_d = b_mag;
            sreg_d = a_mag;
            if (Op_B == '0) begin
              // Divide by zero completes at once without iterating.
              state_d = S_DONE;
              hi_d    = Op_A;
              lo_d    = '1;
              dbz_d   = 1'b1;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            areg_d  = a_mag;
            sreg_d  = b_mag;
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        acc_d  = acc_step;
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (mul_exit) begin
          acc_d   = mul_final;
          state_d = S_FIX;
        end
      end

      S_DIV: begin
        rem_d  = div_ge ? (div_trial[WIDTH-1:0] - areg_q) : div_trial[WIDTH-1:0];
        sreg_d = {sreg_q[WIDTH-2:0], div_ge};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_step) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    // A flush discards the operation. Architectural state is untouched and
    // no done is produced. This also wins over a start in the same cycle.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: datapath registers are not reset. Every field is loaded when an
  // operation is accepted, before it is read.
  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    acc_q     <= acc_d;
    rem_q     <= rem_d;
    sreg_q    <= sreg_d;
    areg_q    <= areg_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign stall       = busy || (start && (is_muldiv || is_mf) &&
                                !((state_q == S_IDLE) || (state_q == S_DONE)));
  assign div_by_zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
//
// Directed bench for mdu_sequencer. Inputs are driven and outputs sampled on
// the falling edge, so "cycle N+k" below means the period after the k-th
// rising edge counted from the one that sampled start.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFLO  = 6'b010010;

`ifdef MDU_EARLY_EXIT_EN
  localparam int EE_BUSY = 3;   // |Op_B| = 3: highest set bit index 1, plus 2
`else
  localparam int EE_BUSY = 33;
`endif

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic        busy, done, stall, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, bcnt, scnt, dcnt;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Funct       (funct),
    .Op_A        (op_a),
    .Op_B        (op_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .stall       (stall),
    .div_by_zero (div_by_zero),
    .HI          (hi),
    .LO          (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in cycle N+1. Returns in the done cycle, with lat = k for cycle
  // N+k. busy_o and stall_o count the cycles before done. A timeout returns
  // lat = 0, which no latency check accepts.
  task automatic wait_done(output int lat_o, output int busy_o, output int stall_o);
    lat_o = 0; busy_o = 0; stall_o = 0;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin
        lat_o = i;
        break;
      end
      busy_o  += int'(busy);
      stall_o += int'(stall);
      tick();
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    funct = f; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt, scnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct = '0; op_a = '0; op_b = '0;
    @(negedge clk);
    tick(); tick();

    // ---- reset state ----
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;
    tick();

    // ---- MULTU max x max: full latency ----
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_lat", lat, 34);
    check("multu_busy", bcnt, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    tick();
    check("multu_done_pulse", done, 0);
    check("multu_idle_busy", busy, 0);

    // ---- signed multiply and divide ----
    run_op(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    check("mult_neg_lat", lat, bcnt + 1);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_neg_lat", lat, 34);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    // ---- divide by zero, then a normal divide clears the flag ----
    run_op(F_DIVU, 32'd100, 32'd0);
    check("dbz_lat", lat, 1);
    check("dbz_busy", bcnt, 0);
    check("dbz_hi", hi, 32'd100);
    check("dbz_lo", lo, 32'hFFFF_FFFF);
    check("dbz_flag", div_by_zero, 1);
    run_op(F_DIVU, 32'd100, 32'd7);
    check("divu_flag_clr", div_by_zero, 0);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    tick();

    // ---- flush at cycle N+10 aborts without commit ----
    funct = F_MULT; op_a = 32'd5; op_b = 32'h8000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_no_done", done, 0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      dcnt += int'(done);
      tick();
    end
    check("flush_done_cnt", dcnt, 0);
    check("flush_hi", hi, 32'd2);
    check("flush_lo", lo, 32'd14);

    // ---- reset in the middle of a divide ----
    funct = F_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_hi", hi, 0);
    check("rstmid_lo", lo, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      dcnt += int'(done);
      tick();
    end
    check("rstmid_done_cnt", dcnt, 0);

    // ---- MFLO held by stall while a multiply is in flight ----
    funct = F_MULTU; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    funct = F_MFLO;            // start stays high: pending MFLO
    wait_done(lat, bcnt, scnt);
    check("mflo_stall_cnt", scnt, lat - 1);
    check("mflo_release", stall, 0);
    check("mflo_lo", lo, 32'd15);
    start = 1'b0;
    tick();
    check("mflo_no_accept", busy, 0);

    // ---- second MULT held during busy, accepted in the DONE cycle ----
    funct = F_MULTU; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    tick();
    funct = F_MULT; op_a = 32'hFFFF_FFFE; op_b = 32'd4;
    wait_done(lat, bcnt, scnt);
    check("b2b_first_lo", lo, 32'd6);
    check("b2b_first_stall", scnt, lat - 1);
    tick();
    start = 1'b0;
    check("b2b_second_busy", busy, 1);
    wait_done(lat, bcnt, scnt);
    check("b2b_second_lat", lat, bcnt + 1);
    check("b2b_second_hi", hi, 32'hFFFF_FFFF);
    check("b2b_second_lo", lo, 32'hFFFF_FFF8);
    tick();

    // ---- short multiplier: early-exit latency when enabled ----
    run_op(F_MULTU, 32'h1234_5678, 32'h0000_0003);
    check("ee_busy", bcnt, EE_BUSY);
    check("ee_lat", lat, EE_BUSY + 1);
    check("ee_hi", hi, 32'h0000_0000);
    check("ee_lo", lo, 32'h369D_0368);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
